dmem_responder: RTL and testbench

- Handshaked data-memory responder serving the MEM-stage load/store initiator.
- Services byte, half and word accesses with sign/zero extension and byte-lane write steering.
- Configurable wait states; flags misaligned and out-of-range accesses.
- Sits behind the MEM pipeline stage, replacing the single-cycle data memory when multi-cycle memory timing is modelled.

---
 rtl/dmem_responder.sv | 197 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Handshaked data-memory responder with byte/half/word access, extension and wait states.
// Optional saturating activity counters are enabled with `define DMEM_PERF_CNT_EN.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_type,
  input  logic        req_u,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_PERF_CNT_EN
  ,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic [15:0] err_count
`endif
);

  localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic        we_r;
  logic        u_r;
  logic [1:0]  type_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] mem_r [DEPTH_WORDS];

  logic [IDX_W-1:0] idx_s;
  logic [1:0]       lane_s;
  logic [31:0]      rd_word_s;
  logic [7:0]       byte_s;
  logic [15:0]      half_s;
  logic [31:0]      load_s;
  logic             err_s;
  logic [3:0]       be_s;
  logic [31:0]      wdata_lane_s;
  logic             access_s;
  logic             mem_we_s;

  assign idx_s     = addr_r[IDX_W+1:2];
  assign lane_s    = addr_r[1:0];
  assign rd_word_s = mem_r[idx_s];
  assign byte_s    = rd_word_s[{lane_s, 3'b000} +: 8];
  assign half_s    = rd_word_s[{addr_r[1], 4'b0000} +: 16];
  // The access happens on the edge that leaves WAIT with the counter exhausted.
  assign access_s  = (state_r == ST_WAIT) && (cnt_r == 4'd0);
  assign mem_we_s  = access_s && we_r && !err_s;

  // Alignment, type and range check on the latched request.
  always_comb begin
    err_s = 1'b0;
    case (type_r)
      2'b00:   err_s = 1'b0;
      2'b01:   err_s = addr_r[0];
      2'b10:   err_s = (addr_r[1:0] != 2'b00);
      default: err_s = 1'b1;
    endcase
    if ({1'b0, addr_r} >= ADDR_LIMIT) begin
      err_s = 1'b1;
    end else begin
      err_s = err_s;
    end
  end

  // Load extraction with sign/zero extension and store lane steering.
  always_comb begin
    load_s       = 32'd0;
    be_s         = 4'b0000;
    wdata_lane_s = wdata_r;
    case (type_r)
      2'b00: begin
        load_s       = u_r ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
        be_s         = 4'b0001 << lane_s;
        wdata_lane_s = {4{wdata_r[7:0]}};
      end
      2'b01: begin
        load_s       = u_r ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
        be_s         = addr_r[1] ? 4'b1100 : 4'b0011;
        wdata_lane_s = {2{wdata_r[15:0]}};
      end
      2'b10: begin
        load_s       = rd_word_s;
        be_s         = 4'b1111;
        wdata_lane_s = wdata_r;
      end
      default: begin
        load_s       = 32'd0;
        be_s         = 4'b0000;
        wdata_lane_s = wdata_r;
      end
    endcase
  end

  // Byte-lane write port; array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we_s && be_s[i]) begin
        mem_r[idx_s][8*i +: 8] <= wdata_lane_s[8*i +: 8];
      end
    end
  end

  // Request/response FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 4'd0;
      we_r      <= 1'b0;
      u_r       <= 1'b0;
      type_r    <= 2'b00;
      addr_r    <= 32'd0;
      wdata_r   <= 32'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            we_r      <= req_we;
            u_r       <= req_u;
            type_r    <= req_type;
            addr_r    <= req_addr;
            wdata_r   <= req_wdata;
            cnt_r     <= WAIT_INIT;
            req_ready <= 1'b0;
            state_r   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_r == 4'd0) begin
            rsp_valid <= 1'b1;
            rsp_err   <= err_s;
            rsp_rdata <= (err_s || we_r) ? 32'd0 : load_s;
            state_r   <= ST_RESP;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            req_ready <= 1'b1;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DMEM_PERF_CNT_EN
  // Saturating event counters, bumped once per completed response handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count  <= 16'd0;
      wr_count  <= 16'd0;
      err_count <= 16'd0;
    end else if ((state_r == ST_RESP) && rsp_ready) begin
      if (rsp_err) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end else if (we_r) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: byte-addressed reference model plus directed vectors.
module tb_dmem_responder;
  localparam int DEPTH = 1024;
  localparam int W     = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_u;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_type;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
`ifdef DMEM_PERF_CNT_EN
  logic [15:0] rd_count, wr_count, err_count;
`endif

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_type(req_type), .req_u(req_u),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
`ifdef DMEM_PERF_CNT_EN
    , .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
`endif
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        we;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  bmem [0:4*DEPTH-1];
  int          checks = 0;
  int          failures = 0;
  int          rd_m = 0, wr_m = 0, err_m = 0;
  logic [31:0] got_d;
  logic        got_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Little-endian byte memory: the response is whatever the access rules say.
  function automatic void model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] typ, input logic u,
                                output logic [31:0] rd, output logic err);
    int size;
    logic [31:0] v;
    size = (typ == 2'd0) ? 1 : (typ == 2'd1) ? 2 : (typ == 2'd2) ? 4 : 0;
    err = 1'b0;
    rd = 32'd0;
    if (size == 0) err = 1'b1;
    else if (addr >= 32'(4 * DEPTH)) err = 1'b1;
    else if ((addr % size) != 0) err = 1'b1;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) bmem[addr + i] = wdata[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = bmem[addr + i];
        if (!u && size < 4 && v[8*size-1])
          for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
        rd = v;
      end
    end
  endfunction

  // Compare every cycle a response is presented; retire it when the handshake will happen.
  always @(negedge clk) begin
    #1;
    if (rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response");
      end else begin
        chk("rsp_rdata", rsp_rdata, exp_q[0].rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_q[0].err});
        chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
        if (rsp_ready) begin
          if (exp_q[0].err) err_m++;
          else if (exp_q[0].we) wr_m++;
          else rd_m++;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] typ, input logic u, input int hold,
                        output logic [31:0] od, output logic oe);
    exp_t e;
    int n;
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    req_type = typ; req_u = u; rsp_ready = (hold == 0);
    model(we, addr, wdata, typ, u, e.rdata, e.err);
    e.we = we;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    // Scramble the request bus: latched fields must not follow it.
    req_valid = 1'b0; req_we = ~we; req_addr = 32'hFFFF_FFFC; req_wdata = 32'h5555_5555; req_u = ~u;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("latency", n, W + 1);
    od = rsp_rdata;
    oe = rsp_err;
    for (int i = 0; i < hold; i++) begin
      chk("req_ready_hold", {31'd0, req_ready}, 32'd0);
      chk("rsp_valid_hold", {31'd0, rsp_valid}, 32'd1);
      req_valid = (i == 1); req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'd0; req_type = 2'b10;
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    n = 0;
    while (rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("handshake", n, 1);
    chk("req_ready_after", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
`ifdef DMEM_PERF_CNT_EN
    chk({tag, "_rd_count"}, {16'd0, rd_count}, 32'd0);
    chk({tag, "_wr_count"}, {16'd0, wr_count}, 32'd0);
    chk({tag, "_err_count"}, {16'd0, err_count}, 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_type = 2'b10; req_u = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b1;

    // Word store/load round trip.
    do_req(1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 0, got_d, got_e);
    chk("sw_rdata", got_d, 32'd0);
    do_req(1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 0, got_d, got_e);
    chk("lw_0x10", got_d, 32'hDEADBEEF);
    chk("lw_0x10_err", {31'd0, got_e}, 32'd0);

    // Sub-word extension.
    do_req(1'b1, 32'h20, 32'h80FF7F01, 2'b10, 1'b0, 0, got_d, got_e);
    do_req(1'b0, 32'h23, 32'd0, 2'b00, 1'b0, 0, got_d, got_e);
    chk("lb_0x23", got_d, 32'hFFFFFF80);
    do_req(1'b0, 32'h23, 32'd0, 2'b00, 1'b1, 0, got_d, got_e);
    chk("lbu_0x23", got_d, 32'h00000080);
    do_req(1'b0, 32'h22, 32'd0, 2'b01, 1'b0, 0, got_d, got_e);
    chk("lh_0x22", got_d, 32'hFFFF80FF);
    do_req(1'b0, 32'h20, 32'd0, 2'b01, 1'b1, 0, got_d, got_e);
    chk("lhu_0x20", got_d, 32'h00007F01);
    do_req(1'b0, 32'h21, 32'd0, 2'b00, 1'b0, 0, got_d, got_e);
    chk("lb_0x21", got_d, 32'h0000007F);

    // Lane-preserving stores, with junk in the unused store-data bits.
    do_req(1'b1, 32'h30, 32'h11223344, 2'b10, 1'b0, 0, got_d, got_e);
    do_req(1'b1, 32'h31, 32'hFFFFFFAA, 2'b00, 1'b0, 0, got_d, got_e);
    do_req(1'b1, 32'h32, 32'h1234BEEF, 2'b01, 1'b0, 0, got_d, got_e);
    do_req(1'b0, 32'h30, 32'd0, 2'b10, 1'b0, 0, got_d, got_e);
    chk("lw_0x30", got_d, 32'hBEEFAA44);

    // Errors, including an out-of-range store that would alias word 0.
    do_req(1'b1, 32'h0, 32'h0BADF00D, 2'b10, 1'b0, 0, got_d, got_e);
    do_req(1'b0, 32'h41, 32'd0, 2'b01, 1'b0, 0, got_d, got_e);
    chk("lh_0x41_err", {31'd0, got_e}, 32'd1);
    chk("lh_0x41_rdata", got_d, 32'd0);
    do_req(1'b1, 32'h1000, 32'hDEADDEAD, 2'b10, 1'b0, 0, got_d, got_e);
    chk("sw_0x1000_err", {31'd0, got_e}, 32'd1);
    do_req(1'b0, 32'h0, 32'd0, 2'b10, 1'b0, 0, got_d, got_e);
    chk("lw_0x0_kept", got_d, 32'h0BADF00D);
    do_req(1'b0, 32'h44, 32'd0, 2'b11, 1'b0, 0, got_d, got_e);
    chk("type11_err", {31'd0, got_e}, 32'd1);
    do_req(1'b1, 32'h32, 32'hCAFEF00D, 2'b10, 1'b0, 0, got_d, got_e);
    do_req(1'b1, 32'h33, 32'h0000CAFE, 2'b01, 1'b0, 0, got_d, got_e);
    do_req(1'b0, 32'h30, 32'd0, 2'b10, 1'b0, 0, got_d, got_e);
    chk("lw_0x30_kept", got_d, 32'hBEEFAA44);

    // Top-of-array boundary.
    do_req(1'b1, 32'hFFC, 32'hA5000000, 2'b10, 1'b0, 0, got_d, got_e);
    do_req(1'b0, 32'hFFF, 32'd0, 2'b00, 1'b1, 0, got_d, got_e);
    chk("lbu_0xfff", got_d, 32'h000000A5);
    do_req(1'b0, 32'hFFFE_0000, 32'd0, 2'b00, 1'b1, 0, got_d, got_e);
    chk("lbu_far_err", {31'd0, got_e}, 32'd1);

    // Backpressure with an intruding request that must be ignored.
    do_req(1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 5, got_d, got_e);
    chk("lw_backpressure", got_d, 32'hDEADBEEF);
    repeat (W + 3) begin
      @(negedge clk);
      chk("no_stray_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    do_req(1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 0, got_d, got_e);
    chk("lw_0x10_after_bp", got_d, 32'hDEADBEEF);

`ifdef DMEM_PERF_CNT_EN
    @(negedge clk);
    chk("rd_count", {16'd0, rd_count}, 32'(rd_m));
    chk("wr_count", {16'd0, wr_count}, 32'(wr_m));
    chk("err_count", {16'd0, err_count}, 32'(err_m));
`endif

    // Reset while a store sits in WAIT: it must never commit.
    do_req(1'b1, 32'h50, 32'h0, 2'b10, 1'b0, 0, got_d, got_e);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h50; req_wdata = 32'h12345678;
    req_type = 2'b10; req_u = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #1 rst = 1'b0;
    #1 chk_reset_outputs("midwait");
    rd_m = 0; wr_m = 0; err_m = 0;
    repeat (W + 2) @(negedge clk);
    chk_reset_outputs("midwait_held");
    rst = 1'b1;
    do_req(1'b0, 32'h50, 32'd0, 2'b10, 1'b0, 0, got_d, got_e);
    chk("lw_0x50_after_rst", got_d, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
